// File: rtl/adma_state_machine.sv
// adma_state_machine: ADMA2 descriptor sequencer walking a descriptor table and driving fetch/transfer engines
// Ports: CLK/RESET_L (async active-low) clock and reset; start/abort/base_address control;
// fetch_* descriptor read handshake with descriptor input; tfr_* transfer handshake;
// busy/state/xfer_complete/desc_int/adma_error/error_state status to the host register block.
module adma_state_machine #(
  parameter int DESC_BYTES = 8,
  parameter int ERR_CODE_W = 2
) (
  input  logic                  CLK,
  input  logic                  RESET_L,
  input  logic                  start,
  input  logic                  abort,
  input  logic [63:0]           base_address,
  output logic                  fetch_start,
  output logic [63:0]           fetch_address,
  input  logic                  fetch_done,
  input  logic                  fetch_error,
  input  logic [63:0]           descriptor,
  output logic                  tfr_start,
  output logic [63:0]           tfr_address,
  output logic [16:0]           tfr_length,
  input  logic                  tfr_done,
  output logic                  busy,
  output logic [1:0]            state,
  output logic                  xfer_complete,
  output logic                  desc_int,
  output logic                  adma_error,
  output logic [ERR_CODE_W-1:0] error_state
);
  typedef enum logic [1:0] {ST_STOP = 2'd0, ST_FDS = 2'd1, ST_CADR = 2'd2, ST_TFR = 2'd3} state_t;
  state_t                state_q, state_d;
  logic [63:0]           sys_addr_q, sys_addr_d, fetch_address_q, fetch_address_d, tfr_address_q, tfr_address_d;
  logic [52:0]           desc_q, desc_d;
  logic [16:0]           tfr_length_q, tfr_length_d;
  logic [ERR_CODE_W-1:0] error_state_q, error_state_d;
  logic fetch_start_q, fetch_start_d, tfr_start_q, tfr_start_d, xfer_complete_q, xfer_complete_d;
  logic desc_int_q, desc_int_d, adma_error_q, adma_error_d, busy_q, busy_d;
  logic        d_valid, d_end, d_int;
  logic [1:0]  d_act;
  logic [15:0] d_len;
  logic [31:0] d_addr;
  logic [63:0] next_addr;
  logic        unused_bits;
  // Only the decoded fields of a descriptor are kept; reserved bits are dropped at latch time.
  assign unused_bits = ^{descriptor[15:6], descriptor[3]};
  assign {d_addr, d_len, d_act, d_int, d_end, d_valid} = desc_q;
  // A link target replaces the already-incremented address.
  assign next_addr = (d_act == 2'b11) ? {32'b0, d_addr} : sys_addr_q;
  always_comb begin
    state_d         = state_q;
    sys_addr_d      = sys_addr_q;
    desc_d          = desc_q;
    fetch_address_d = fetch_address_q;
    tfr_address_d   = tfr_address_q;
    tfr_length_d    = tfr_length_q;
    error_state_d   = error_state_q;
    fetch_start_d   = 1'b0;
    tfr_start_d     = 1'b0;
    xfer_complete_d = 1'b0;
    desc_int_d      = 1'b0;
    adma_error_d    = 1'b0;
    case (state_q)
      ST_STOP: if (start) begin
        state_d         = ST_FDS;
        sys_addr_d      = base_address;
        error_state_d   = '0;
        fetch_start_d   = 1'b1;
        fetch_address_d = base_address;
      end
      // A done coincident with our own fetch_start pulse belongs to no request of ours.
      ST_FDS: if (fetch_done && !fetch_start_q) begin
        if (fetch_error) begin
          state_d       = ST_STOP;
          adma_error_d  = 1'b1;
          error_state_d = ERR_CODE_W'(1);
        end else begin
          state_d    = ST_CADR;
          desc_d     = {descriptor[63:16], descriptor[5:4], descriptor[2:0]};
          sys_addr_d = sys_addr_q + 64'(DESC_BYTES);
        end
      end
      ST_CADR: if (!d_valid) begin
        state_d       = ST_STOP;
        adma_error_d  = 1'b1;
        error_state_d = ERR_CODE_W'(2);
      end else if (d_act == 2'b10) begin
        state_d       = ST_TFR;
        tfr_start_d   = 1'b1;
        tfr_address_d = {32'b0, d_addr};
        tfr_length_d  = {~|d_len, d_len};
      end else begin
        sys_addr_d      = next_addr;
        desc_int_d      = d_int;
        state_d         = d_end ? ST_STOP : ST_FDS;
        xfer_complete_d = d_end;
        fetch_start_d   = !d_end;
        fetch_address_d = d_end ? fetch_address_q : next_addr;
      end
      ST_TFR: if (tfr_done) begin
        desc_int_d      = d_int;
        state_d         = d_end ? ST_STOP : ST_FDS;
        xfer_complete_d = d_end;
        fetch_start_d   = !d_end;
        fetch_address_d = d_end ? fetch_address_q : sys_addr_q;
      end
      default: state_d = ST_STOP;
    endcase
    if (abort) begin
      state_d         = ST_STOP;
      sys_addr_d      = sys_addr_q;
      desc_d          = desc_q;
      fetch_address_d = fetch_address_q;
      tfr_address_d   = tfr_address_q;
      tfr_length_d    = tfr_length_q;
      error_state_d   = error_state_q;
      fetch_start_d   = 1'b0;
      tfr_start_d     = 1'b0;
      xfer_complete_d = 1'b0;
      desc_int_d      = 1'b0;
      adma_error_d    = 1'b0;
    end
    busy_d = state_d != ST_STOP;
  end
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q         <= ST_STOP;
      sys_addr_q      <= '0;
      desc_q          <= '0;
      fetch_address_q <= '0;
      tfr_address_q   <= '0;
      tfr_length_q    <= '0;
      error_state_q   <= '0;
      fetch_start_q   <= 1'b0;
      tfr_start_q     <= 1'b0;
      xfer_complete_q <= 1'b0;
      desc_int_q      <= 1'b0;
      adma_error_q    <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      sys_addr_q      <= sys_addr_d;
      desc_q          <= desc_d;
      fetch_address_q <= fetch_address_d;
      tfr_address_q   <= tfr_address_d;
      tfr_length_q    <= tfr_length_d;
      error_state_q   <= error_state_d;
      fetch_start_q   <= fetch_start_d;
      tfr_start_q     <= tfr_start_d;
      xfer_complete_q <= xfer_complete_d;
      desc_int_q      <= desc_int_d;
      adma_error_q    <= adma_error_d;
      busy_q          <= busy_d;
    end
  end
  assign state         = state_q;
  assign busy          = busy_q;
  assign fetch_start   = fetch_start_q;
  assign fetch_address = fetch_address_q;
  assign tfr_start     = tfr_start_q;
  assign tfr_address   = tfr_address_q;
  assign tfr_length    = tfr_length_q;
  assign xfer_complete = xfer_complete_q;
  assign desc_int      = desc_int_q;
  assign adma_error    = adma_error_q;
  assign error_state   = error_state_q;
endmodule

// File: tb/tb_adma_state_machine.sv
// tb_adma_state_machine: scoreboard bench for adma_state_machine with a table-walking reference model
module tb_adma_state_machine;
  localparam int EV_INT = 0, EV_DONE = 1, EV_ERR = 2, EV_FETCH = 3, EV_TFR = 4;
  localparam int R_START = 0, R_FD = 1, R_TD = 2;
  typedef struct {int k; logic [63:0] a; logic [16:0] l; int r; int d;} ev_t;
  logic CLK = 0, RESET_L = 0, start = 0, abort = 0, fetch_done = 0, fetch_error = 0, tfr_done = 0;
  logic [63:0] base_address = 0, descriptor = 0;
  logic fetch_start, tfr_start, busy, xfer_complete, desc_int, adma_error;
  logic [63:0] fetch_address, tfr_address;
  logic [16:0] tfr_length;
  logic [1:0] state, error_state;
  logic [154:0] outs;
  logic [63:0] mem [logic [63:0]];
  ev_t exp_q[$];
  int total = 0, bad = 0, cyc = 0;
  int last_ev [3] = '{0, 0, 0};
  bit fetch_auto = 1, tfr_auto = 1, err_en = 0;
  logic [63:0] err_addr = 0;

  adma_state_machine dut (
    .CLK(CLK), .RESET_L(RESET_L), .start(start), .abort(abort), .base_address(base_address),
    .fetch_start(fetch_start), .fetch_address(fetch_address), .fetch_done(fetch_done),
    .fetch_error(fetch_error), .descriptor(descriptor), .tfr_start(tfr_start),
    .tfr_address(tfr_address), .tfr_length(tfr_length), .tfr_done(tfr_done), .busy(busy),
    .state(state), .xfer_complete(xfer_complete), .desc_int(desc_int), .adma_error(adma_error),
    .error_state(error_state)
  );

  assign outs = {fetch_start, fetch_address, tfr_start, tfr_address, tfr_length, busy, state,
                 xfer_complete, desc_int, adma_error, error_state};
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (start) last_ev[R_START] <= cyc + 1;
    if (fetch_done) last_ev[R_FD] <= cyc + 1;
    if (tfr_done) last_ev[R_TD] <= cyc + 1;
  end

  function automatic void chk(string n, logic [159:0] got, logic [159:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endfunction

  function automatic void push(int k, logic [63:0] a, logic [16:0] l, int r, int d);
    exp_q.push_back('{k, a, l, r, d});
  endfunction

  function automatic void chk_ev(string n, int k, logic [63:0] a, logic [16:0] l);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s unexpected pulse a=%0h l=%0h", n, a, l);
      return;
    end
    e = exp_q.pop_front();
    if (e.k != k || e.a !== a || e.l !== l || cyc - last_ev[e.r] != e.d) begin
      bad++;
      $display("FAIL %s got kind=%0d a=%0h l=%0h lat=%0d exp kind=%0d a=%0h l=%0h lat=%0d",
               n, k, a, l, cyc - last_ev[e.r], e.k, e.a, e.l, e.d);
    end
  endfunction

  // Monitor: pulses sharing a cycle are checked in the order the model emits them.
  always @(negedge CLK) if (RESET_L) begin
    if (desc_int) chk_ev("desc_int", EV_INT, 0, 0);
    if (xfer_complete) chk_ev("xfer_complete", EV_DONE, 0, 0);
    if (adma_error) chk_ev("adma_error", EV_ERR, {62'd0, error_state}, 0);
    if (fetch_start) chk_ev("fetch_start", EV_FETCH, fetch_address, 0);
    if (tfr_start) chk_ev("tfr_start", EV_TFR, tfr_address, tfr_length);
  end

  // Reference model: follows the table in memory and lists the pulses the host should see,
  // each with the input event it follows and the number of extra edges after it.
  function automatic void model(logic [63:0] base);
    logic [63:0] a, nxt, dsc;
    int r, d;
    push(EV_FETCH, base, 0, R_START, 0);
    a = base;
    for (int s = 0; s < 64; s++) begin
      if (err_en && a == err_addr) begin push(EV_ERR, 1, 0, R_FD, 0); return; end
      dsc = mem.exists(a) ? mem[a] : 64'd0;
      nxt = a + 64'd8;
      if (!dsc[0]) begin push(EV_ERR, 2, 0, R_FD, 1); return; end
      if (dsc[5:4] == 2'b10) begin
        push(EV_TFR, {32'd0, dsc[63:32]}, (dsc[31:16] == 0) ? 17'd65536 : {1'b0, dsc[31:16]}, R_FD, 1);
        r = R_TD; d = 0;
      end else begin
        r = R_FD; d = 1;
        if (dsc[5:4] == 2'b11) nxt = {32'd0, dsc[63:32]};
      end
      if (dsc[2]) push(EV_INT, 0, 0, r, d);
      if (dsc[1]) begin push(EV_DONE, 0, 0, r, d); return; end
      push(EV_FETCH, nxt, 0, r, d);
      a = nxt;
    end
  endfunction

  initial forever begin
    logic [63:0] a;
    @(negedge CLK);
    if (fetch_start && fetch_auto) begin
      a = fetch_address;
      repeat ($urandom_range(1, 3)) @(negedge CLK);
      fetch_done = 1;
      fetch_error = err_en && a == err_addr;
      descriptor = mem.exists(a) ? mem[a] : 64'd0;
      @(negedge CLK);
      fetch_done = 0;
      fetch_error = 0;
      descriptor = {$urandom, $urandom};
    end
  end

  initial forever begin
    @(negedge CLK);
    if (tfr_start && tfr_auto) begin
      repeat ($urandom_range(1, 3)) @(negedge CLK);
      tfr_done = 1;
      @(negedge CLK);
      tfr_done = 0;
    end
  end

  task automatic pulse_start(input logic [63:0] base);
    @(negedge CLK);
    start = 1;
    base_address = base;
    @(negedge CLK);
    start = 0;
    base_address = {$urandom, $urandom};
    chk("start_state", state, 1);
    chk("start_busy", busy, 1);
    chk("start_err_clr", error_state, 0);
  endtask

  task automatic run(input logic [63:0] base);
    int n = 0;
    model(base);
    pulse_start(base);
    while (busy && n < 400) begin @(negedge CLK); n++; end
    chk("idle", busy, 0);
    repeat (4) @(negedge CLK);
    chk("drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic build(input logic [63:0] base, input int mode);
    logic [63:0] a, dsc;
    logic [31:0] tgt;
    logic [1:0] act;
    int k, bi;
    mem.delete();
    err_en = 0;
    k = $urandom_range(1, 6);
    bi = $urandom_range(0, k - 1);
    a = base;
    for (int i = 0; i < k; i++) begin
      act = 2'($urandom_range(0, 3));
      tgt = (act == 2'b11) ? 32'(i + 1) * 32'h10000 + 32'($urandom_range(0, 255)) * 32'd8 : $urandom;
      dsc = {tgt, ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom), 10'($urandom), act,
             1'($urandom), 1'($urandom), i == k - 1, !(mode == 3 && i == bi)};
      if (mode == 4 && i == bi) begin err_en = 1; err_addr = a; end
      mem[a] = dsc;
      a = (act == 2'b11) ? {32'd0, tgt} : a + 64'd8;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [63:0] b;
    repeat (3) @(negedge CLK);
    chk("reset_outputs", outs, 0);
    RESET_L = 1;
    // single transfer
    mem.delete();
    mem[64] = 64'h00001000_0200_0023;
    run(64);
    // link to 0x400 then tran+end
    mem.delete();
    mem[64] = 64'h00000400_0000_0031;
    mem[64'h400] = 64'h00002000_0010_0023;
    run(64);
    // zero length with int, then nop+end at 72
    mem.delete();
    mem[64] = 64'h00003000_0000_0025;
    mem[72] = 64'h00000000_0000_0003;
    run(64);
    // invalid descriptor
    mem.delete();
    mem[64] = 64'h00001000_0200_0022;
    run(64);
    chk("inv_error_state", error_state, 2);
    // fetch error, then a clean start clears error_state
    mem[64] = 64'h00001000_0200_0023;
    err_en = 1;
    err_addr = 64;
    run(64);
    chk("ferr_error_state", error_state, 1);
    chk("ferr_state", state, 0);
    err_en = 0;
    run(64);
    // abort during transfer; a late tfr_done must be ignored
    mem.delete();
    mem[64] = 64'h00005000_0040_0021;
    tfr_auto = 0;
    push(EV_FETCH, 64, 0, R_START, 0);
    push(EV_TFR, 64'h5000, 17'h40, R_FD, 1);
    pulse_start(64);
    n = 0;
    while (!tfr_start && n < 50) begin @(negedge CLK); n++; end
    chk("abort_in_tfr", state, 3);
    @(negedge CLK);
    abort = 1;
    @(negedge CLK);
    abort = 0;
    chk("abort_state", state, 0);
    chk("abort_busy", busy, 0);
    tfr_done = 1;
    @(negedge CLK);
    tfr_done = 0;
    repeat (3) @(negedge CLK);
    chk("abort_stray_tfr", state, 0);
    chk("abort_drained", exp_q.size(), 0);
    exp_q.delete();
    tfr_auto = 1;
    // asynchronous reset while fetching
    fetch_auto = 0;
    push(EV_FETCH, 64'h1234_5678_9abc_def0, 0, R_START, 0);
    pulse_start(64'h1234_5678_9abc_def0);
    @(negedge CLK);
    chk("fds_state", state, 1);
    #2 RESET_L = 0;
    #1 chk("async_reset_outputs", outs, 0);
    @(negedge CLK);
    RESET_L = 1;
    fetch_auto = 1;
    chk("reset_drained", exp_q.size(), 0);
    exp_q.delete();
    // randomized tables
    for (int t = 0; t < 30; t++) begin
      b = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 : {$urandom, $urandom};
      build(b, $urandom_range(0, 4));
      run(b);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
